// File: rtl/axis_axil_pkg.sv
// Shared types and constants for the stream-driven AXI-Lite initiator.
package axis_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_B,
    READ_ADDR,
    WAIT_R,
    RESPOND
  } state_t;

  localparam int unsigned CMD_READ_BIT = 0;
  localparam int unsigned RSP_RESP_LSB = 0;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/axis_axil_master_if.sv
// Stream and AXI-Lite bundles used by axis_axil_master.
interface axi_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;
  logic [USER_WIDTH-1:0] user;
  logic                  tlast;

  modport master (output valid, data, dest, user, tlast, input ready);
  modport slave  (input valid, data, dest, user, tlast, output ready);
endinterface

interface axi_lite #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axis_axil_master.sv
// Turns each command stream beat into one AXI-Lite write or read; read results
// return as a single-beat response stream. One transaction in flight.
module axis_axil_master
  import axis_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  axi_stream.slave    cmd,
  axi_lite.master     axil,
  axi_stream.master   rsp,
  output logic        error,
  output logic [15:0] error_count
);

  state_t                state;
  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic cmd_hs, aw_hs, w_hs, aw_fin, w_fin, b_hs, ar_hs, r_hs, rsp_hs, resp_err;

  // Only dest[ADDR_WIDTH-1:0] and user[CMD_READ_BIT] carry meaning on the command port.
  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, cmd.tlast, cmd.user, cmd.dest};

  assign axil.awaddr = addr_q;
  assign axil.araddr = addr_q;
  assign axil.wdata  = wdata_q;
  assign axil.wstrb  = '1;
  assign axil.awprot = '0;
  assign axil.arprot = '0;

  assign cmd_hs   = (state == IDLE)      && cmd.valid    && cmd.ready;
  assign aw_hs    = (state == WRITE)     && axil.awvalid && axil.awready;
  assign w_hs     = (state == WRITE)     && axil.wvalid  && axil.wready;
  assign aw_fin   = aw_done || aw_hs;
  assign w_fin    = w_done  || w_hs;
  assign b_hs     = (state == WAIT_B)    && axil.bvalid  && axil.bready;
  assign ar_hs    = (state == READ_ADDR) && axil.arvalid && axil.arready;
  assign r_hs     = (state == WAIT_R)    && axil.rvalid  && axil.rready;
  assign rsp_hs   = (state == RESPOND)   && rsp.valid    && rsp.ready;
  assign resp_err = (b_hs && (axil.bresp != RESP_OKAY)) ||
                    (r_hs && (axil.rresp != RESP_OKAY));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cmd.ready    <= 1'b0;
      axil.awvalid <= 1'b0;
      axil.wvalid  <= 1'b0;
      axil.bready  <= 1'b0;
      axil.arvalid <= 1'b0;
      axil.rready  <= 1'b0;
      rsp.valid    <= 1'b0;
      rsp.data     <= '0;
      rsp.dest     <= '0;
      rsp.user     <= '0;
      rsp.tlast    <= 1'b0;
      error        <= 1'b0;
      error_count  <= '0;
    end else begin
      error <= resp_err;
      if (resp_err && (error_count != '1)) begin
        error_count <= error_count + 16'd1;
      end

      case (state)
        IDLE: begin
          cmd.ready <= 1'b1;
          if (cmd_hs) begin
            cmd.ready <= 1'b0;
            addr_q    <= cmd.dest[ADDR_WIDTH-1:0];
            wdata_q   <= cmd.data;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd.user[CMD_READ_BIT]) begin
              state        <= READ_ADDR;
              axil.arvalid <= 1'b1;
            end else begin
              state        <= WRITE;
              axil.awvalid <= 1'b1;
              axil.wvalid  <= 1'b1;
            end
          end
        end

        // AW and W retire independently; the done flags remember which already went.
        WRITE: begin
          if (aw_hs) begin
            axil.awvalid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (w_hs) begin
            axil.wvalid <= 1'b0;
            w_done      <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state       <= WAIT_B;
            axil.bready <= 1'b1;
          end
        end

        WAIT_B: begin
          if (b_hs) begin
            axil.bready <= 1'b0;
            cmd.ready   <= 1'b1;
            state       <= IDLE;
          end
        end

        READ_ADDR: begin
          if (ar_hs) begin
            axil.arvalid <= 1'b0;
            axil.rready  <= 1'b1;
            state        <= WAIT_R;
          end
        end

        WAIT_R: begin
          if (r_hs) begin
            axil.rready <= 1'b0;
            rsp.valid   <= 1'b1;
            rsp.data    <= axil.rdata;
            rsp.dest    <= DEST_WIDTH'(addr_q);
            rsp.user    <= USER_WIDTH'(axil.rresp) << RSP_RESP_LSB;
            rsp.tlast   <= 1'b1;
            state       <= RESPOND;
          end
        end

        RESPOND: begin
          if (rsp_hs) begin
            rsp.valid <= 1'b0;
            cmd.ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_axil_master.sv
// Directed vector bench for axis_axil_master with a reactive AXI-Lite slave model.
module tb_axis_axil_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        error;
  logic [15:0] error_count;

  always #5 clock = ~clock;

  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(32), .USER_WIDTH(32)) cmd_if ();
  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(32), .USER_WIDTH(32)) rsp_if ();
  axi_lite   #(.DATA_WIDTH(32), .ADDR_WIDTH(32))                  axil_if ();

  axis_axil_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEST_WIDTH(32),
    .USER_WIDTH(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd_if),
    .axil       (axil_if),
    .rsp        (rsp_if),
    .error      (error),
    .error_count(error_count)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // slave configuration
  int          aw_lat = 0, w_lat = 0;
  bit          early = 0, r_block = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // monitor state; handshake edges are recorded as the clock edge on which they occur
  int          aw_total, w_total, b_total, ar_total, r_total, err_pulses;
  int          aw_edge, w_edge, b_edge, ar_edge, r_edge;
  int          aw_wait, w_wait;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  // Slave drives on the falling edge, then records handshakes that the next rising edge completes.
  always @(negedge clock) begin
    if (!reset) begin
      axil_if.awready = 1'b0; axil_if.wready = 1'b0; axil_if.arready = 1'b0;
      axil_if.bvalid  = 1'b0; axil_if.bresp  = 2'b00;
      axil_if.rvalid  = 1'b0; axil_if.rresp  = 2'b00; axil_if.rdata = '0;
      aw_total = 0; w_total = 0; b_total = 0; ar_total = 0; r_total = 0; err_pulses = 0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (axil_if.awvalid) begin
        axil_if.awready = early || (aw_wait >= aw_lat);
        aw_wait++;
      end else begin
        axil_if.awready = early;
        aw_wait = 0;
      end
      if (axil_if.wvalid) begin
        axil_if.wready = early || (w_wait >= w_lat);
        w_wait++;
      end else begin
        axil_if.wready = early;
        w_wait = 0;
      end
      axil_if.arready = early || axil_if.arvalid;
      axil_if.bvalid  = (aw_total > b_total) && (w_total > b_total);
      axil_if.bresp   = axil_if.bvalid ? bresp_cfg : 2'b00;
      axil_if.rvalid  = (ar_total > r_total) && !r_block;
      axil_if.rresp   = axil_if.rvalid ? rresp_cfg : 2'b00;
      axil_if.rdata   = axil_if.rvalid ? rdata_cfg : 32'h0;

      if (error) err_pulses++;
      if (axil_if.awvalid && axil_if.awready) begin
        aw_total++; aw_edge = cyc + 1; cap_awaddr = axil_if.awaddr;
      end
      if (axil_if.wvalid && axil_if.wready) begin
        w_total++; w_edge = cyc + 1; cap_wdata = axil_if.wdata; cap_wstrb = axil_if.wstrb;
      end
      if (axil_if.bvalid && axil_if.bready) begin
        b_total++; b_edge = cyc + 1;
      end
      if (axil_if.arvalid && axil_if.arready) begin
        ar_total++; ar_edge = cyc + 1; cap_araddr = axil_if.araddr;
      end
      if (axil_if.rvalid && axil_if.rready) begin
        r_total++; r_edge = cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Edge offsets e_* are relative to the command handshake edge T.
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_lat;
    int          w_lat;
    int          hold;
    bit          early;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_user;
    int          e_a;
    int          e_w;
    int          e_resp;
    int          e_rsp;
    int          e_hs;
    int          e_rdy;
    int          e_pulses;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic send_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] data,
                          input string tag, output int t);
    bit ok = 0;
    cmd_if.valid = 1'b1;
    cmd_if.data  = data;
    cmd_if.dest  = addr;
    cmd_if.user  = 32'(rd);
    cmd_if.tlast = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (cmd_if.ready) begin ok = 1; break; end
      @(negedge clock);
    end
    chk({tag, " cmd accepted"}, 32'(ok), 32'd1);
    t = cyc + 1;
    @(negedge clock);
    cmd_if.valid = 1'b0;
    cmd_if.data  = '0;
    cmd_if.dest  = '0;
    cmd_if.user  = '0;
    chk({tag, " cmd.ready busy"}, 32'(cmd_if.ready), 32'd0);
  endtask

  task automatic wait_ready(input string tag, output int rdy);
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      if (cmd_if.ready) begin ok = 1; break; end
      @(negedge clock);
    end
    chk({tag, " cmd.ready return"}, 32'(ok), 32'd1);
    rdy = cyc + 1;
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string tag;
    int    t, rdy, rsp_e, hs;
    int    a0, w0, b0, ar0, r0, p0;
    bit    ok;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    aw_lat = v.aw_lat; w_lat = v.w_lat; early = v.early;
    bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
    a0 = aw_total; w0 = w_total; b0 = b_total; ar0 = ar_total; r0 = r_total; p0 = err_pulses;

    send_cmd(v.rd, v.addr, v.wdata, tag, t);
    if (!v.rd) begin
      wait_ready(tag, rdy);
      chk({tag, " aw count"}, 32'(aw_total - a0), 32'd1);
      chk({tag, " w count"},  32'(w_total - w0),  32'd1);
      chk({tag, " b count"},  32'(b_total - b0),  32'd1);
      chk({tag, " ar count"}, 32'(ar_total - ar0), 32'd0);
      chk({tag, " awaddr"},   cap_awaddr, v.e_addr);
      chk({tag, " wdata"},    cap_wdata,  v.e_data);
      chk({tag, " wstrb"},    32'(cap_wstrb), 32'hF);
      chk({tag, " aw edge"},  32'(aw_edge - t), 32'(v.e_a));
      chk({tag, " w edge"},   32'(w_edge - t),  32'(v.e_w));
      chk({tag, " b edge"},   32'(b_edge - t),  32'(v.e_resp));
      chk({tag, " ready edge"}, 32'(rdy - t),   32'(v.e_rdy));
    end else begin
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        if (rsp_if.valid) begin ok = 1; break; end
        @(negedge clock);
      end
      chk({tag, " rsp.valid seen"}, 32'(ok), 32'd1);
      rsp_e = cyc + 1;
      chk({tag, " rsp.data"},  rsp_if.data, v.e_data);
      chk({tag, " rsp.dest"},  rsp_if.dest, v.e_addr);
      chk({tag, " rsp.user"},  rsp_if.user, v.e_user);
      chk({tag, " rsp.tlast"}, 32'(rsp_if.tlast), 32'd1);
      for (int k = 0; k < v.hold; k++) begin
        chk($sformatf("%s hold%0d rsp.valid", tag, k), 32'(rsp_if.valid), 32'd1);
        chk($sformatf("%s hold%0d rsp.data", tag, k),  rsp_if.data, v.e_data);
        chk($sformatf("%s hold%0d cmd.ready", tag, k), 32'(cmd_if.ready), 32'd0);
        @(negedge clock);
      end
      rsp_if.ready = 1'b1;
      hs = cyc + 1;
      @(negedge clock);
      rsp_if.ready = 1'b0;
      chk({tag, " rsp.valid dropped"}, 32'(rsp_if.valid), 32'd0);
      wait_ready(tag, rdy);
      chk({tag, " ar count"}, 32'(ar_total - ar0), 32'd1);
      chk({tag, " r count"},  32'(r_total - r0),   32'd1);
      chk({tag, " aw count"}, 32'(aw_total - a0),  32'd0);
      chk({tag, " araddr"},   cap_araddr, v.e_addr);
      chk({tag, " ar edge"},  32'(ar_edge - t), 32'(v.e_a));
      chk({tag, " r edge"},   32'(r_edge - t),  32'(v.e_resp));
      chk({tag, " rsp edge"}, 32'(rsp_e - t),   32'(v.e_rsp));
      chk({tag, " rsp hs edge"}, 32'(hs - t),   32'(v.e_hs));
      chk({tag, " ready edge"},  32'(rdy - t),  32'(v.e_rdy));
    end
    chk({tag, " error pulses"}, 32'(err_pulses - p0), 32'(v.e_pulses));
    chk({tag, " error_count"},  32'(error_count), 32'(v.e_cnt));
  endtask

  initial begin
    int  t;
    bit  ok;
    //        rd addr          wdata         rdata         resp   awl wl hold early e_addr        e_data        e_user a  w  rsp rsp hs rdy pulses cnt
    vecs[0] = '{0, 32'h40, 32'hDEADBEEF, 32'h0,        2'b00, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF, 32'h0, 1, 1, 2, 0, 0, 3, 0, 16'd0};
    vecs[1] = '{1, 32'h44, 32'h0,        32'h12345678, 2'b00, 0, 0, 0, 0, 32'h44, 32'h12345678, 32'h0, 1, 0, 2, 3, 3, 4, 0, 16'd0};
    vecs[2] = '{0, 32'h48, 32'hA5A5A5A5, 32'h0,        2'b00, 0, 3, 0, 0, 32'h48, 32'hA5A5A5A5, 32'h0, 1, 4, 5, 0, 0, 6, 0, 16'd0};
    vecs[3] = '{1, 32'h4C, 32'h0,        32'hCAFEF00D, 2'b00, 0, 0, 5, 0, 32'h4C, 32'hCAFEF00D, 32'h0, 1, 0, 2, 3, 8, 9, 0, 16'd0};
    vecs[4] = '{0, 32'h50, 32'h01020304, 32'h0,        2'b10, 0, 0, 0, 0, 32'h50, 32'h01020304, 32'h0, 1, 1, 2, 0, 0, 3, 1, 16'd1};
    vecs[5] = '{1, 32'h54, 32'h0,        32'h0BADC0DE, 2'b11, 0, 0, 0, 0, 32'h54, 32'h0BADC0DE, 32'h3, 1, 0, 2, 3, 3, 4, 1, 16'd2};
    vecs[6] = '{0, 32'h58, 32'h11223344, 32'h0,        2'b00, 0, 0, 0, 1, 32'h58, 32'h11223344, 32'h0, 1, 1, 2, 0, 0, 3, 0, 16'd2};
    vecs[7] = '{0, 32'h5C, 32'h55667788, 32'h0,        2'b00, 2, 0, 0, 0, 32'h5C, 32'h55667788, 32'h0, 3, 1, 4, 0, 0, 5, 0, 16'd2};

    cmd_if.valid = 1'b0; cmd_if.data = '0; cmd_if.dest = '0; cmd_if.user = '0; cmd_if.tlast = 1'b0;
    rsp_if.ready = 1'b0;

    repeat (3) @(negedge clock);
    chk("reset cmd.ready",   32'(cmd_if.ready),    32'd0);
    chk("reset awvalid",     32'(axil_if.awvalid), 32'd0);
    chk("reset wvalid",      32'(axil_if.wvalid),  32'd0);
    chk("reset arvalid",     32'(axil_if.arvalid), 32'd0);
    chk("reset bready",      32'(axil_if.bready),  32'd0);
    chk("reset rready",      32'(axil_if.rready),  32'd0);
    chk("reset rsp.valid",   32'(rsp_if.valid),    32'd0);
    chk("reset rsp.data",    rsp_if.data,          32'h0);
    chk("reset rsp.user",    rsp_if.user,          32'h0);
    chk("reset rsp.dest",    rsp_if.dest,          32'h0);
    chk("reset rsp.tlast",   32'(rsp_if.tlast),    32'd0);
    chk("reset error",       32'(error),           32'd0);
    chk("reset error_count", 32'(error_count),     32'd0);
    chk("const wstrb",       32'(axil_if.wstrb),   32'hF);
    chk("const prot",        32'({axil_if.awprot, axil_if.arprot}), 32'h0);

    reset = 1'b1;
    @(negedge clock);
    chk("idle cmd.ready", 32'(cmd_if.ready), 32'd1);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // reset while the read waits on RVALID
    r_block = 1'b1; early = 1'b0; aw_lat = 0; w_lat = 0;
    @(negedge clock);
    send_cmd(1'b1, 32'h60, 32'h0, "rst", t);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (axil_if.rready) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("rst reached WAIT_R", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst rready",      32'(axil_if.rready),  32'd0);
    chk("rst arvalid",     32'(axil_if.arvalid), 32'd0);
    chk("rst awvalid",     32'(axil_if.awvalid), 32'd0);
    chk("rst wvalid",      32'(axil_if.wvalid),  32'd0);
    chk("rst bready",      32'(axil_if.bready),  32'd0);
    chk("rst rsp.valid",   32'(rsp_if.valid),    32'd0);
    chk("rst cmd.ready",   32'(cmd_if.ready),    32'd0);
    chk("rst error_count", 32'(error_count),     32'd0);
    repeat (2) @(negedge clock);
    r_block = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    chk("rst idle cmd.ready", 32'(cmd_if.ready), 32'd1);
    chk("rst no rsp",         32'(rsp_if.valid), 32'd0);
    #1;
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
